// File: rtl/axis_traffic_bench.sv
// AXI-Stream traffic generator and checker with packet length/count control,
// receive back-pressure pattern and a throughput cycle counter behind a small register port.
module axis_traffic_bench #(
    parameter int          C_AXIS_DATA_WIDTH  = 256,
    parameter int          C_AXIS_TUSER_WIDTH = 128,
    parameter int          C_LEN_WIDTH        = 16,
    parameter logic [23:0] USER_MAGIC_CODE    = 24'haecafe
) (
    input  logic                            ACLK,
    input  logic                            RESET,
    input  logic                            REG_WR,
    input  logic                            REG_RD,
    input  logic [3:0]                      REG_ADDR,
    input  logic [31:0]                     REG_WDATA,
    output logic [31:0]                     REG_RDATA,
    output logic                            M_AXIS_TVALID,
    output logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                            M_AXIS_TLAST,
    input  logic                            M_AXIS_TREADY,
    input  logic                            S_AXIS_TVALID,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                            S_AXIS_TLAST,
    output logic                            S_AXIS_TREADY,
    output logic                            dbg_busy,
    output logic                            dbg_done,
    output logic                            dbg_err
);
    localparam int          LANES   = C_AXIS_DATA_WIDTH / 32;
    localparam logic [31:0] LANES32 = 32'(LANES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   state;
    logic                     m_valid, s_ready_q;
    logic [C_LEN_WIDTH-1:0]   pkt_len, pkt_count, tx_pkts, rx_pkts, tx_beat, len_eff;
    logic [31:0]              rdy_mask, rx_errs, cycles, rx_beat, rd_mux;
    logic                     busy, start, stop, clr, m_fire, s_fire, rx_bad;
    logic                     unused_bits;

    function automatic logic [C_LEN_WIDTH-1:0] sat_len(input logic [C_LEN_WIDTH-1:0] v);
        return (&v) ? v : v + C_LEN_WIDTH'(1);
    endfunction

    function automatic logic [31:0] sat_32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [C_AXIS_DATA_WIDTH-1:0] lane_pattern(input logic [31:0] beat);
        logic [C_AXIS_DATA_WIDTH-1:0] d;
        d = '0;
        for (int i = 0; i < LANES; i++) d[32*i +: 32] = beat * LANES32 + 32'(i);
        return d;
    endfunction

    assign busy   = (state == S_RUN) || (state == S_DRAIN);
    // STOP wins over START when both are set in the same CTRL write
    assign stop   = REG_WR && (REG_ADDR == 4'd0) && REG_WDATA[1];
    assign start  = REG_WR && (REG_ADDR == 4'd0) && REG_WDATA[0] && !REG_WDATA[1];
    assign clr    = REG_WR && (REG_ADDR == 4'd0) && REG_WDATA[2];
    assign len_eff = (pkt_len == '0) ? C_LEN_WIDTH'(1) : pkt_len;

    assign M_AXIS_TVALID = m_valid;
    assign M_AXIS_TLAST  = m_valid && (tx_beat == len_eff - C_LEN_WIDTH'(1));
    assign M_AXIS_TDATA  = m_valid ? lane_pattern(32'(tx_beat)) : '0;
    assign M_AXIS_TSTRB  = {(C_AXIS_DATA_WIDTH/8){m_valid}};
    always_comb begin
        M_AXIS_TUSER = '0;
        if (m_valid) M_AXIS_TUSER[23:0] = USER_MAGIC_CODE;
    end

    assign S_AXIS_TREADY = s_ready_q && busy;
    assign m_fire = m_valid && M_AXIS_TREADY;
    assign s_fire = S_AXIS_TREADY && S_AXIS_TVALID;
    assign rx_bad = (S_AXIS_TDATA != lane_pattern(rx_beat)) ||
                    (S_AXIS_TUSER[23:0] != USER_MAGIC_CODE);

    assign dbg_busy = busy;
    assign dbg_done = (state == S_DONE);
    assign dbg_err  = (rx_errs != 32'd0);
    assign unused_bits = ^{S_AXIS_TSTRB, S_AXIS_TUSER};

    always_comb begin
        rd_mux = 32'd0;
        case (REG_ADDR)
            4'd1:    rd_mux = 32'(pkt_len);
            4'd2:    rd_mux = 32'(pkt_count);
            4'd3:    rd_mux = rdy_mask;
            4'd4:    rd_mux = {30'd0, busy, dbg_done};
            4'd5:    rd_mux = 32'(tx_pkts);
            4'd6:    rd_mux = 32'(rx_pkts);
            4'd7:    rd_mux = rx_errs;
            4'd8:    rd_mux = cycles;
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge ACLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            m_valid   <= 1'b0;
            s_ready_q <= 1'b0;
            pkt_len   <= C_LEN_WIDTH'(1);
            pkt_count <= '0;
            rdy_mask  <= 32'd0;
            tx_pkts   <= '0;
            rx_pkts   <= '0;
            tx_beat   <= '0;
            rx_beat   <= 32'd0;
            rx_errs   <= 32'd0;
            cycles    <= 32'd0;
            REG_RDATA <= 32'd0;
        end else begin
            REG_RDATA <= REG_RD ? rd_mux : 32'd0;
            if (REG_WR && REG_ADDR == 4'd1) pkt_len   <= REG_WDATA[C_LEN_WIDTH-1:0];
            if (REG_WR && REG_ADDR == 4'd2) pkt_count <= REG_WDATA[C_LEN_WIDTH-1:0];
            if (REG_WR && REG_ADDR == 4'd3) rdy_mask  <= REG_WDATA;

            // back-pressure pattern lags CYCLES by one cycle and starts deasserted
            s_ready_q <= busy && ((cycles & rdy_mask) == 32'd0);
            if (busy) cycles <= sat_32(cycles);

            if (m_fire) begin
                if (M_AXIS_TLAST) begin
                    tx_pkts <= sat_len(tx_pkts);
                    tx_beat <= '0;
                    if (sat_len(tx_pkts) == pkt_count) m_valid <= 1'b0;
                end else begin
                    tx_beat <= tx_beat + C_LEN_WIDTH'(1);
                end
            end

            if (s_fire) begin
                if (rx_bad) rx_errs <= sat_32(rx_errs);
                if (S_AXIS_TLAST) begin
                    rx_pkts <= sat_len(rx_pkts);
                    rx_beat <= 32'd0;
                end else begin
                    rx_beat <= rx_beat + 32'd1;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_RUN;
                        m_valid <= (pkt_count != '0);
                        tx_pkts <= '0;
                        rx_pkts <= '0;
                        tx_beat <= '0;
                        rx_beat <= 32'd0;
                        rx_errs <= 32'd0;
                        cycles  <= 32'd0;
                    end
                end
                S_RUN: begin
                    if (tx_pkts == pkt_count) begin
                        state   <= S_DRAIN;
                        m_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (rx_pkts == pkt_count) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase

            if (stop) begin
                state   <= S_IDLE;
                m_valid <= 1'b0;
            end
            if (clr) begin
                tx_pkts <= '0;
                rx_pkts <= '0;
                rx_errs <= 32'd0;
                cycles  <= 32'd0;
            end
        end
    end
endmodule
